writeback_arbiter_n: RTL and testbench

Parametrised writeback stage for an NUM_PE-wide processing-element array sharing a single register-file write port. Each PE presents a writeback candidate: ALU result, memory read data or PC+4, chosen by a 2-bit per-PE select. Selected results are buffered in a per-PE FIFO of depth DEPTH, and a round-robin arbiter drains one entry per cycle onto a registered register-file write port. The block replaces the fixed two-PE, two-way writeback mux and sits between the memory/writeback pipeline registers and the register file.

---
 rtl/writeback_arbiter_n.sv | 171 +++++++++++++++++
 tb/tb_writeback_arbiter_n.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_arbiter_n.sv
// Purpose : NUM_PE writeback candidates -> per-PE FIFO -> round-robin -> one registered RF write port.
// Latency : transfer at edge k is buffered at k, drives rf_we_o after edge k+1 (2 edges) when uncontended.
// Backpr. : ready_o[i] = !full[i], from the pre-edge count only; a full FIFO refuses even if popped that edge.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   valid_i/ready_o   per-PE handshake (transfer on valid_i[i] && ready_o[i])
//   reg_write_i, rd_i per-PE write enable and destination (rd==0 or !reg_write -> discarded)
//   result_src_i      per-PE 2-bit select: 00 ALU, 01 read data, 10 PC+4, 11 ALU
//   alu_result_i, read_data_i, pc_plus4_i   per-PE candidate values
//   rf_we_o, rf_wa_o, rf_wd_o, rf_pe_o      registered register-file write and its source PE
//   busy_o            any FIFO holding data or a write currently presented
module writeback_arbiter_n #(
  parameter int NUM_PE = 2,
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int DEPTH  = 4,
  localparam int PW    = (NUM_PE > 1) ? $clog2(NUM_PE) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_PE-1:0]          valid_i,
  output logic [NUM_PE-1:0]          ready_o,
  input  logic [NUM_PE-1:0]          reg_write_i,
  input  logic [2*NUM_PE-1:0]        result_src_i,
  input  logic [DATA_W*NUM_PE-1:0]   alu_result_i,
  input  logic [DATA_W*NUM_PE-1:0]   read_data_i,
  input  logic [DATA_W*NUM_PE-1:0]   pc_plus4_i,
  input  logic [REG_AW*NUM_PE-1:0]   rd_i,
  output logic                       rf_we_o,
  output logic [REG_AW-1:0]          rf_wa_o,
  output logic [DATA_W-1:0]          rf_wd_o,
  output logic [PW-1:0]              rf_pe_o,
  output logic                       busy_o
);

  localparam int AW = $clog2(DEPTH);

  // One buffered writeback: destination register plus the already-selected result.
  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] dat;
  } wb_entry_t;

  logic [NUM_PE-1:0] push;
  logic [NUM_PE-1:0] pop;
  logic [NUM_PE-1:0] empty;
  logic [NUM_PE-1:0] full;
  wb_entry_t         push_ent [NUM_PE];
  wb_entry_t         head_ent [NUM_PE];

  logic              gnt_vld;
  logic [PW-1:0]     gnt_idx;
  wb_entry_t         gnt_ent;
  logic [PW-1:0]     ptr;
  logic [PW-1:0]     ptr_nxt;

  assign ready_o = ~full;

  // ---------------------------------------------------------------------------
  // Per-PE result select and FIFO
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < NUM_PE; i++) begin : g_pe
    logic [1:0]        src;
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] sel;
    wb_entry_t         mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;

    assign src = result_src_i[2*i +: 2];
    assign rd  = rd_i[REG_AW*i +: REG_AW];

    always_comb begin
      case (src)
        2'b01:   sel = read_data_i[DATA_W*i +: DATA_W];
        2'b10:   sel = pc_plus4_i[DATA_W*i +: DATA_W];
        default: sel = alu_result_i[DATA_W*i +: DATA_W];
      endcase
    end

    // Handshake completes whenever valid && ready; only real register
    // writes (enabled, rd != x0) take a FIFO slot.
    assign push[i]     = valid_i[i] && !full[i] && reg_write_i[i] && (rd != '0);
    assign push_ent[i] = '{rd: rd, dat: sel};

    // Only the arbiter pops, and it only grants non-empty FIFOs, so a pop
    // never sees an empty FIFO and a push into an empty one is never
    // visible to the arbiter until the following cycle.
    assign pop[i] = gnt_vld && (gnt_idx == PW'(i));

    always_ff @(posedge clk) begin
      if (rst) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push[i]) wr_ptr <= wr_ptr + AW'(1);
        if (pop[i])  rd_ptr <= rd_ptr + AW'(1);
        case ({push[i], pop[i]})
          2'b10:   count <= count + (AW+1)'(1);
          2'b01:   count <= count - (AW+1)'(1);
          default: count <= count;
        endcase
      end
    end

    // Storage needs no reset: a slot is only read after it has been written.
    always_ff @(posedge clk) begin
      if (push[i]) mem[wr_ptr] <= push_ent[i];
    end

    assign head_ent[i] = mem[rd_ptr];
    assign empty[i]    = (count == '0);
    assign full[i]     = (count == (AW+1)'(DEPTH));
  end

  // ---------------------------------------------------------------------------
  // Round-robin arbiter: first non-empty FIFO at ptr, ptr+1, ... (mod NUM_PE)
  // ---------------------------------------------------------------------------
  logic [PW:0]   scan_sum;
  logic [PW-1:0] scan_idx;

  always_comb begin
    gnt_vld  = 1'b0;
    gnt_idx  = '0;
    scan_sum = '0;
    scan_idx = '0;
    for (int k = 0; k < NUM_PE; k++) begin
      // ptr + k never exceeds 2*NUM_PE-2, so one conditional subtract wraps it.
      scan_sum = {1'b0, ptr} + (PW+1)'(k);
      if (scan_sum >= (PW+1)'(NUM_PE)) begin
        scan_sum = scan_sum - (PW+1)'(NUM_PE);
      end
      scan_idx = scan_sum[PW-1:0];
      if (!gnt_vld && !empty[scan_idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = scan_idx;
      end
    end
  end

  assign gnt_ent = head_ent[gnt_idx];
  assign ptr_nxt = (gnt_idx == PW'(NUM_PE - 1)) ? '0 : gnt_idx + PW'(1);

  // ---------------------------------------------------------------------------
  // Arbiter pointer and registered register-file write port
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr     <= '0;
      rf_we_o <= 1'b0;
      rf_wa_o <= '0;
      rf_wd_o <= '0;
      rf_pe_o <= '0;
    end else begin
      rf_we_o <= gnt_vld;
      // Address/data/source hold when idle so the port stays quiet.
      if (gnt_vld) begin
        ptr     <= ptr_nxt;
        rf_wa_o <= gnt_ent.rd;
        rf_wd_o <= gnt_ent.dat;
        rf_pe_o <= gnt_idx;
      end
    end
  end

  assign busy_o = (|(~empty)) || rf_we_o;

endmodule

// File: tb/tb_writeback_arbiter_n.sv
// Scoreboard bench for writeback_arbiter_n (NUM_PE=2, DATA_W=32, REG_AW=5, DEPTH=4).
// Stimulus pushes hand-computed expected writes in grant order; a negedge
// monitor pops and compares each rf_we_o pulse.
module tb_writeback_arbiter_n;

  localparam int NUM_PE = 2;
  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int DEPTH  = 4;

  logic                     clk;
  logic                     rst;
  logic [NUM_PE-1:0]        valid;
  logic [NUM_PE-1:0]        ready;
  logic [NUM_PE-1:0]        reg_write;
  logic [2*NUM_PE-1:0]      result_src;
  logic [DATA_W*NUM_PE-1:0] alu;
  logic [DATA_W*NUM_PE-1:0] rdat;
  logic [DATA_W*NUM_PE-1:0] pc4;
  logic [REG_AW*NUM_PE-1:0] rd;
  logic                     rf_we;
  logic [REG_AW-1:0]        rf_wa;
  logic [DATA_W-1:0]        rf_wd;
  logic [0:0]               rf_pe;
  logic                     busy;

  typedef struct packed {
    logic [REG_AW-1:0] wa;
    logic [DATA_W-1:0] wd;
    logic [0:0]        pe;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  writeback_arbiter_n #(
    .NUM_PE(NUM_PE), .DATA_W(DATA_W), .REG_AW(REG_AW), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .valid_i(valid), .ready_o(ready), .reg_write_i(reg_write),
    .result_src_i(result_src), .alu_result_i(alu), .read_data_i(rdat),
    .pc_plus4_i(pc4), .rd_i(rd),
    .rf_we_o(rf_we), .rf_wa_o(rf_wa), .rf_wd_o(rf_wd), .rf_pe_o(rf_pe),
    .busy_o(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_pe(input int pe, input logic vld, input logic rw, input logic [4:0] r,
                          input logic [1:0] src, input logic [31:0] a,
                          input logic [31:0] m, input logic [31:0] p);
    valid[pe]              = vld;
    reg_write[pe]          = rw;
    rd[pe*REG_AW +: REG_AW] = r;
    result_src[pe*2 +: 2]  = src;
    alu[pe*DATA_W +: DATA_W]  = a;
    rdat[pe*DATA_W +: DATA_W] = m;
    pc4[pe*DATA_W +: DATA_W]  = p;
  endtask

  task automatic idle_pe(input int pe);
    drive_pe(pe, 1'b0, 1'b0, 5'd0, 2'b00, 32'h0, 32'h0, 32'h0);
  endtask

  function automatic void expect_wr(input logic [4:0] wa, input logic [31:0] wd, input logic pe);
    exp_t e;
    e.wa = wa;
    e.wd = wd;
    e.pe = pe;
    exp_q.push_back(e);
  endfunction

  // Monitor: every presented write must match the oldest expected one.
  always @(negedge clk) begin
    if (rf_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_write: got wa=%0h wd=%0h pe=%0h, expected no write",
                 rf_wa, rf_wd, rf_pe);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rf_write{wa,wd,pe}", {26'd0, rf_wa, rf_wd, rf_pe}, {26'd0, e.wa, e.wd, e.pe});
      end
    end
  end

  initial begin
    int ia;
    int ib;
    int cyc;
    int stalls;
    int full_at;
    logic fire0;
    logic fire1;

    rst = 1'b1;
    valid = '0; reg_write = '0; result_src = '0;
    alu = '0; rdat = '0; pc4 = '0; rd = '0;
    repeat (2) tick();
    rst = 1'b0;

    // Reset state
    chk("reset_rf_we", rf_we, 1'b0);
    chk("reset_rf_wa", rf_wa, 5'd0);
    chk("reset_rf_wd", rf_wd, 32'd0);
    chk("reset_rf_pe", rf_pe, 1'b0);
    chk("reset_busy",  busy,  1'b0);
    chk("reset_ready", ready, 2'b11);

    // Uncontended latency: PE0 ALU 0x1234 to x5
    drive_pe(0, 1, 1, 5'd5, 2'b00, 32'h0000_1234, 32'hAAAA_0000, 32'hBBBB_0000);
    expect_wr(5'd5, 32'h0000_1234, 1'b0);
    tick();                                   // edge 1: transfer
    idle_pe(0);
    chk("lat_e1_rf_we", rf_we, 1'b0);
    chk("lat_e1_busy",  busy,  1'b1);
    tick();                                   // edge 2: write presented
    chk("lat_e2_rf_we", rf_we, 1'b1);
    tick();                                   // edge 3
    chk("lat_e3_rf_we", rf_we, 1'b0);
    chk("lat_e3_busy",  busy,  1'b0);

    // Source select on PE1: 01 read data, 10 PC+4, 11 ALU
    drive_pe(1, 1, 1, 5'd1, 2'b01, 32'h1111_0001, 32'hDEAD_BEEF, 32'h2222_0001);
    expect_wr(5'd1, 32'hDEAD_BEEF, 1'b1);
    tick();
    drive_pe(1, 1, 1, 5'd2, 2'b10, 32'h1111_0002, 32'h3333_0002, 32'h0000_0040);
    expect_wr(5'd2, 32'h0000_0040, 1'b1);
    tick();
    drive_pe(1, 1, 1, 5'd3, 2'b11, 32'h0000_0007, 32'h3333_0003, 32'h2222_0003);
    expect_wr(5'd3, 32'h0000_0007, 1'b1);
    tick();
    idle_pe(1);
    tick();
    chk("src_third_rf_we", rf_we, 1'b1);
    tick();
    chk("src_done_rf_we", rf_we, 1'b0);
    repeat (2) tick();

    // Discards: rd=0 with write enable, and rd=9 without
    drive_pe(0, 1, 1, 5'd0, 2'b00, 32'h5555_5555, 32'h0, 32'h0);
    drive_pe(1, 1, 0, 5'd9, 2'b00, 32'h6666_6666, 32'h0, 32'h0);
    tick();
    idle_pe(0);
    idle_pe(1);
    chk("discard_ready", ready, 2'b11);
    chk("discard_busy_e1", busy, 1'b0);
    tick();
    chk("discard_busy_e2", busy, 1'b0);
    chk("discard_rf_we", rf_we, 1'b0);
    repeat (2) tick();

    // Simultaneous pair, ptr=0: PE0 first, twice
    drive_pe(0, 1, 1, 5'd7, 2'b00, 32'h0000_0070, 32'h0, 32'h0);
    drive_pe(1, 1, 1, 5'd8, 2'b00, 32'h0000_0080, 32'h0, 32'h0);
    expect_wr(5'd7, 32'h0000_0070, 1'b0);
    expect_wr(5'd8, 32'h0000_0080, 1'b1);
    tick();
    idle_pe(0); idle_pe(1);
    repeat (4) tick();
    drive_pe(0, 1, 1, 5'd10, 2'b00, 32'h0000_00A0, 32'h0, 32'h0);
    drive_pe(1, 1, 1, 5'd11, 2'b00, 32'h0000_00B0, 32'h0, 32'h0);
    expect_wr(5'd10, 32'h0000_00A0, 1'b0);
    expect_wr(5'd11, 32'h0000_00B0, 1'b1);
    tick();
    idle_pe(0); idle_pe(1);
    repeat (4) tick();

    // Three entries per PE: grants alternate 0,1,0,1,0,1
    for (int j = 0; j < 3; j++) begin
      expect_wr(5'(16 + j), 32'h100 + j, 1'b0);
      expect_wr(5'(20 + j), 32'h200 + j, 1'b1);
    end
    for (int j = 0; j < 3; j++) begin
      drive_pe(0, 1, 1, 5'(16 + j), 2'b00, 32'h100 + j, 32'h0, 32'h0);
      drive_pe(1, 1, 1, 5'(20 + j), 2'b00, 32'h200 + j, 32'h0, 32'h0);
      tick();
    end
    idle_pe(0); idle_pe(1);
    repeat (8) tick();

    // Backpressure: PE0 pushes 4, PE1 pushes 7 with held valid.
    // Alternating drain lets PE1 reach 4 entries after its 6th transfer;
    // one stalled cycle, then the held 7th is accepted at 3 entries.
    for (int k = 0; k < 4; k++) begin
      expect_wr(5'(24 + k), 32'hA00 + k, 1'b0);
      expect_wr(5'(8 + k),  32'hB00 + k, 1'b1);
    end
    for (int k = 4; k < 7; k++) expect_wr(5'(8 + k), 32'hB00 + k, 1'b1);
    ia = 0; ib = 0; cyc = 0; stalls = 0; full_at = -1;
    while ((ia < 4 || ib < 7) && cyc < 40) begin
      if (ia < 4) drive_pe(0, 1, 1, 5'(24 + ia), 2'b00, 32'hA00 + ia, 32'hFFFF_0000, 32'h0);
      else        idle_pe(0);
      if (ib < 7) drive_pe(1, 1, 1, 5'(8 + ib), 2'b01, 32'hEEEE_0000, 32'hB00 + ib, 32'h0);
      else        idle_pe(1);
      @(negedge clk);
      fire0 = valid[0] && ready[0];
      fire1 = valid[1] && ready[1];
      if (valid[1] && !ready[1]) begin
        if (stalls == 0) full_at = ib;
        stalls++;
      end
      tick();
      if (fire0) ia++;
      if (fire1) ib++;
      cyc++;
    end
    idle_pe(0); idle_pe(1);
    chk("bp_all_transferred", {ia[7:0], ib[7:0]}, {8'd4, 8'd7});
    chk("bp_full_after_push", full_at, 6);
    chk("bp_stall_cycles", stalls, 1);
    repeat (10) tick();

    // Reset mid-drain: 3 entries per PE, three writes emerge, then reset
    expect_wr(5'd17, 32'hC00, 1'b0);
    expect_wr(5'd21, 32'hD00, 1'b1);
    expect_wr(5'd18, 32'hC01, 1'b0);
    for (int j = 0; j < 3; j++) begin
      drive_pe(0, 1, 1, 5'(17 + j), 2'b00, 32'hC00 + j, 32'h0, 32'h0);
      drive_pe(1, 1, 1, 5'(21 + j), 2'b00, 32'hD00 + j, 32'h0, 32'h0);
      tick();
    end
    idle_pe(0); idle_pe(1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_pending", exp_q.size(), 0);
    chk("mid_rst_rf_we", rf_we, 1'b0);
    chk("mid_rst_busy",  busy,  1'b0);
    chk("mid_rst_ready", ready, 2'b11);
    chk("mid_rst_rf_out", {rf_wa, rf_wd, rf_pe}, 38'd0);
    repeat (8) tick();
    chk("post_rst_busy", busy, 1'b0);

    // ptr was 1 before reset; after reset PE0 must win first
    drive_pe(0, 1, 1, 5'd26, 2'b00, 32'h0000_00E0, 32'h0, 32'h0);
    drive_pe(1, 1, 1, 5'd27, 2'b00, 32'h0000_00F0, 32'h0, 32'h0);
    expect_wr(5'd26, 32'h0000_00E0, 1'b0);
    expect_wr(5'd27, 32'h0000_00F0, 1'b1);
    tick();
    idle_pe(0); idle_pe(1);

    for (int w = 0; w < 20 && exp_q.size() != 0; w++) tick();
    repeat (3) tick();
    chk("drain_leftover", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
